// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/decode/execute controller and sole writer of
// the program-counter register. Optional return stack is enabled with the
// PC_SEQ_CALL_STACK_EN macro; without it Call/Ret are ignored and StackErr is 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for Start after reset
// FETCH  | IMemReq high until IMemAck; Ack loads the instruction register
// DECODE | single cycle; Halt here bumps the PC and parks in HALTED
// EXEC   | waits out Stall, then picks Ret/Call/Branch/increment target
// HALTED | parked; Start resumes fetching at the current PC
module pc_sequencer #(
    parameter int              AW        = 5,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter int              RS_DEPTH  = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          IMemAck,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          BranchValid,
    input  logic          BranchTaken,
    input  logic [AW-1:0] BranchTarget,
    input  logic          Call,
    input  logic          Ret,
    output logic [AW-1:0] PCNext,
    output logic          PCWrite,
    output logic [AW-1:0] PCCur,
    output logic          IMemReq,
    output logic          IRWrite,
    output logic [2:0]    State,
    output logic          Halted,
    output logic          StackErr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_next_q, pc_next_d;
    logic          pc_write_q, pc_write_d;
    logic          ir_write_q, ir_write_d;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] exec_target;
    logic          exec_en;

    assign pc_inc  = pc_q + 1'b1;
    assign exec_en = (state_q == S_EXEC) && !Stall;

`ifdef PC_SEQ_CALL_STACK_EN
    localparam int PW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CW = $clog2(RS_DEPTH + 1);

    // top_q is the next slot to write; when the stack is full that slot holds
    // the oldest entry, so a push naturally overwrites it.
    logic [AW-1:0] stack_q [RS_DEPTH];
    logic [AW-1:0] stack_d [RS_DEPTH];
    logic [PW-1:0] top_q, top_d, top_dec, top_inc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign top_dec = (top_q == '0) ? PW'(RS_DEPTH - 1) : top_q - 1'b1;
    assign top_inc = (top_q == PW'(RS_DEPTH - 1)) ? '0 : top_q + 1'b1;

    // Next-PC selection and stack push/pop; side effects only on a live EXEC edge.
    always_comb begin
        stack_d     = stack_q;
        top_d       = top_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        exec_target = pc_inc;
        if (Ret) begin
            if (cnt_q == '0) begin
                if (exec_en) err_d = 1'b1;
            end else begin
                exec_target = stack_q[top_dec];
                if (exec_en) begin
                    top_d = top_dec;
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end else if (Call) begin
            exec_target = BranchTarget;
            if (exec_en) begin
                stack_d[top_q] = pc_inc;
                top_d          = top_inc;
                if (cnt_q == CW'(RS_DEPTH)) err_d = 1'b1;
                else                        cnt_d = cnt_q + 1'b1;
            end
        end else if (BranchValid && BranchTaken) begin
            exec_target = BranchTarget;
        end
    end

    // Return-stack storage; reset empties it and clears the sticky error.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stack_q <= '{default: '0};
            top_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            stack_q <= stack_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign StackErr = err_q;
`else
    localparam int unused_rs_depth = RS_DEPTH;
    logic unused_call_ret;
    assign unused_call_ret = Call | Ret;

    // Without the stack, next PC is the taken branch target or the increment.
    always_comb begin
        exec_target = (BranchValid && BranchTaken) ? BranchTarget : pc_inc;
    end

    assign StackErr = 1'b0;
`endif

    // Next-state and registered-output decode; strobes default low each cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_next_d  = pc_next_q;
        pc_write_d = 1'b0;
        ir_write_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (IMemAck) begin
                    ir_write_d = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (Halt) begin
                    pc_d       = pc_inc;
                    pc_next_d  = pc_inc;
                    pc_write_d = 1'b1;
                    state_d    = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!Stall) begin
                    pc_d       = exec_target;
                    pc_next_d  = exec_target;
                    pc_write_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_HALTED: begin
                if (Start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VEC;
            pc_next_q  <= RESET_VEC;
            pc_write_q <= 1'b0;
            ir_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_next_q  <= pc_next_d;
            pc_write_q <= pc_write_d;
            ir_write_q <= ir_write_d;
        end
    end

    assign PCCur   = pc_q;
    assign PCNext  = pc_next_q;
    assign PCWrite = pc_write_q;
    assign IRWrite = ir_write_q;
    assign State   = state_q;
    assign IMemReq = (state_q == S_FETCH);
    assign Halted  = (state_q == S_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam int AW       = 5;
    localparam int RS_DEPTH = 4;
    localparam int PCMOD    = 1 << AW;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start, IMemAck, Halt, Stall, BranchValid, BranchTaken, Call, Ret;
    logic [AW-1:0] BranchTarget;
    logic [AW-1:0] PCNext, PCCur;
    logic          PCWrite, IMemReq, IRWrite, Halted, StackErr;
    logic [2:0]    State;

    pc_sequencer #(.AW(AW), .RESET_VEC('0), .RS_DEPTH(RS_DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .IMemAck(IMemAck), .Halt(Halt),
        .Stall(Stall), .BranchValid(BranchValid), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Call(Call), .Ret(Ret),
        .PCNext(PCNext), .PCWrite(PCWrite), .PCCur(PCCur), .IMemReq(IMemReq),
        .IRWrite(IRWrite), .State(State), .Halted(Halted), .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase number follows the documented State encoding.
    int m_phase, m_pc, m_next;
    bit m_pcw, m_irw, m_err;
    int m_stk[$];
    bit prev_pcw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pc = 0; m_next = 0;
        m_pcw = 0; m_irw = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic model_clock();
        int nxt;
        m_pcw = 0;
        m_irw = 0;
        case (m_phase)
            0: if (Start) m_phase = 1;
            1: if (IMemAck) begin m_irw = 1; m_phase = 2; end
            2: if (Halt) begin
                   m_pc = (m_pc + 1) % PCMOD; m_next = m_pc; m_pcw = 1; m_phase = 4;
               end else m_phase = 3;
            3: if (!Stall) begin
                   nxt = (m_pc + 1) % PCMOD;
`ifdef PC_SEQ_CALL_STACK_EN
                   if (Ret) begin
                       if (m_stk.size() == 0) m_err = 1;
                       else nxt = m_stk.pop_back();
                   end else if (Call) begin
                       if (m_stk.size() == RS_DEPTH) begin
                           void'(m_stk.pop_front());
                           m_err = 1;
                       end
                       m_stk.push_back((m_pc + 1) % PCMOD);
                       nxt = int'(BranchTarget);
                   end else if (BranchValid && BranchTaken) nxt = int'(BranchTarget);
`else
                   if (BranchValid && BranchTaken) nxt = int'(BranchTarget);
`endif
                   m_pc = nxt; m_next = nxt; m_pcw = 1; m_phase = 1;
               end
            4: if (Start) m_phase = 1;
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_all(input string w);
        check({w, ":State"},    State,    m_phase);
        check({w, ":PCCur"},    PCCur,    m_pc);
        check({w, ":PCNext"},   PCNext,   m_next);
        check({w, ":PCWrite"},  PCWrite,  m_pcw);
        check({w, ":IRWrite"},  IRWrite,  m_irw);
        check({w, ":IMemReq"},  IMemReq,  (m_phase == 1));
        check({w, ":Halted"},   Halted,   (m_phase == 4));
        check({w, ":StackErr"}, StackErr, m_err);
    endtask

    task automatic zero_inputs();
        Start = 0; IMemAck = 0; Halt = 0; Stall = 0;
        BranchValid = 0; BranchTaken = 0; BranchTarget = '0; Call = 0; Ret = 0;
    endtask

    task automatic step(input string w, input bit st, input bit ack, input bit hl,
                        input bit stl, input bit bv, input bit bt, input int tgt,
                        input bit cl, input bit rt);
        @(negedge Clk);
        Start = st; IMemAck = ack; Halt = hl; Stall = stl;
        BranchValid = bv; BranchTaken = bt; BranchTarget = AW'(tgt); Call = cl; Ret = rt;
        @(posedge Clk);
        model_clock();
        #1;
        check_all(w);
        check({w, ":PCWriteTwice"}, {31'd0, prev_pcw & PCWrite}, 0);
        prev_pcw = PCWrite;
    endtask

    // One instruction starting in FETCH: Ack wait, decode, optional stall, execute.
    task automatic run_instr(input string w, input int ackwait, input bit hl,
                             input int stalls, input bit bv, input bit bt,
                             input int tgt, input bit cl, input bit rt);
        for (int i = 0; i < ackwait; i++) step(w, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(w, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(w, 0, 0, hl, 0, 0, 0, 0, 0, 0);
        if (!hl) begin
            for (int i = 0; i < stalls; i++) step(w, 0, 0, 0, 1, bv, bt, tgt, cl, rt);
            step(w, 0, 0, 0, 0, bv, bt, tgt, cl, rt);
        end
    endtask

    initial begin
        zero_inputs();
        prev_pcw = 0;
        Reset = 1;
        model_reset();
        @(negedge Clk);
        check_all("reset");
        Reset = 0;

        // Asynchronous reset while fetching.
        step("pre_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("pre_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero_inputs();
        @(posedge Clk);
        #3 Reset = 1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge Clk);
        Reset = 0;
        prev_pcw = 0;

        // Start, Ack after three wait cycles, plain increment.
        step("start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("inc", 3, 0, 0, 0, 0, 0, 0, 0);
        check("inc_pc", PCCur, 1);

        // Branch to 31 then increment wraps to 0; not-taken branch increments.
        run_instr("br31", 0, 0, 0, 1, 1, 31, 0, 0);
        run_instr("wrap", 0, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_pcnext", PCNext, 0);
        check("wrap_pcwrite", PCWrite, 1);
        run_instr("ntaken", 1, 0, 0, 1, 0, 9, 0, 0);
        check("ntaken_pc", PCCur, 1);

        // Four-cycle stall with a taken branch to 12.
        run_instr("stall", 0, 0, 4, 1, 1, 12, 0, 0);
        check("stall_pcnext", PCNext, 12);

        // Halt at PC 7, then resume.
        run_instr("br6", 0, 0, 0, 1, 1, 6, 0, 0);
        run_instr("to7", 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("halt", 0, 1, 0, 0, 0, 0, 0, 0);
        check("halt_pcnext", PCNext, 8);
        check("halt_halted", Halted, 1);
        step("halted_idle", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("resume", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("resume_pc", PCCur, 8);
        check("resume_req", IMemReq, 1);

`ifdef PC_SEQ_CALL_STACK_EN
        run_instr("br3", 0, 0, 0, 1, 1, 3, 0, 0);
        run_instr("call", 0, 0, 0, 0, 0, 20, 1, 0);
        check("call_pc", PCCur, 20);
        run_instr("ret", 0, 0, 2, 0, 0, 0, 0, 1);
        check("ret_pc", PCCur, 4);
        run_instr("ret_empty", 0, 0, 0, 0, 0, 0, 0, 1);
        check("ret_empty_pc", PCCur, 5);
        check("ret_empty_err", StackErr, 1);
        for (int i = 0; i < 5; i++) run_instr("calls", 0, 0, 0, 0, 0, 10 + i, 1, 0);
        check("overflow_err", StackErr, 1);
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(negedge Clk);
                zero_inputs();
                Reset = 1;
                model_reset();
                #1;
                check_all("rnd_rst");
                @(negedge Clk);
                Reset = 0;
                prev_pcw = 0;
            end else begin
                step("rnd",
                     $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                     $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, PCMOD - 1)),
                     $urandom_range(0, 19) < 3, $urandom_range(0, 19) < 3);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle fetch/execute controller for the 5-bit program counter register.
- Tracks the current PC and decides the next PC: increment, branch, halt or stall.
- Drives the PC register's load inputs (PCNext/PCWrite), the instruction-memory request and the instruction-register write.
- Sits between the decode/branch logic and the PC register; it is the only writer of that register.

Parameters:
AW, 5, PC/address width; all PC arithmetic is modulo 2^AW.
RESET_VEC, 0, PC value after reset.
RS_DEPTH, 4, return-stack entries (used only when PC_SEQ_CALL_STACK_EN is defined).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  leave IDLE/HALTED and begin fetching.
IMemAck  input  1  instruction memory data valid this cycle.
Halt  input  1  halt request from decode, sampled in DECODE only.
Stall  input  1  hold EXEC, no PC update.
BranchValid  input  1  branch resolved this cycle (EXEC).
BranchTaken  input  1  qualifies BranchValid.
BranchTarget  input  AW  branch/call destination.
Call  input  1  call request in EXEC (optional feature).
Ret  input  1  return request in EXEC (optional feature).
PCNext  output  AW  value for the PC register load port.
PCWrite  output  1  one-cycle PC load strobe.
PCCur  output  AW  current PC; instruction-memory address.
IMemReq  output  1  instruction fetch request.
IRWrite  output  1  one-cycle instruction-register load strobe.
State  output  3  FSM state encoding.
Halted  output  1  high in HALTED.
StackErr  output  1  sticky return-stack over/underflow flag.

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-operation):
- State=IDLE, PCCur=PCNext=RESET_VEC.
- PCWrite=IRWrite=IMemReq=Halted=StackErr=0; stack empty.

State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALTED=4; 5–7 are illegal and return to IDLE.

Output timing:
- IMemReq=(State==FETCH) and Halted=(State==HALTED) are decoded from the state register.
- All other outputs are registered.

State transitions:
- IDLE: Start=1 -> FETCH. Otherwise stay.
- FETCH: IMemReq held high until IMemAck=1. On the Ack edge, IRWrite<=1 for exactly one cycle and State->DECODE. No timeout. IMemAck outside FETCH is ignored.
- DECODE: one cycle.
  - Halt=1 -> PCCur<=PCCur+1, PCNext<=PCCur+1, PCWrite<=1, State->HALTED.
  - Halt=0 -> EXEC.
- EXEC, Stall=1: stay; PCCur/PCNext hold, PCWrite=0.
- EXEC, Stall=0: compute next with priority Ret > Call > (BranchValid&BranchTaken -> BranchTarget) > PCCur+1. On that edge, PCCur<=next, PCNext<=next, PCWrite<=1, State->FETCH.
- PCWrite is high during the first FETCH cycle, so the PC register holds the new value one cycle after PCCur does.
- HALTED: Start=1 -> FETCH at the current PCCur. Otherwise stay.

Rules and boundaries:
- PCWrite is never high for two consecutive cycles.
- Halt outside DECODE is ignored.
- Increment wraps: PCCur=2^AW-1 gives next=0 (31->0 for AW=5).
- BranchValid with BranchTaken=0 behaves as an increment.

Optional Feature:
PC_SEQ_CALL_STACK_EN.

Defined:
- RS_DEPTH-entry circular return stack.
- Call in EXEC (non-stalled): push PCCur+1, next=BranchTarget.
- Ret: pop, next=popped value.
- Push when full: overwrite the oldest entry, set StackErr.
- Ret when empty: next=PCCur+1, set StackErr.
- StackErr clears only on Reset.

Undefined:
- Call and Ret are ignored; next-PC priority reduces to Branch > increment.
- StackErr is tied to 0; ports still exist.

Test Plan:
1. Reset mid-FETCH: Reset=1 asynchronously -> IMemReq=0 and State=0 in the same cycle, PCCur=0.
2. Start, Ack after 3 wait cycles, no branch -> IRWrite one pulse; after EXEC, PCWrite one pulse with PCNext=1, PCCur=1, State=FETCH.
3. PCCur=31 with increment -> PCNext=0, PCWrite=1 (wrap).
4. EXEC with Stall=1 for 4 cycles plus BranchValid=BranchTaken=1, Target=12 -> no PCWrite during the stall; after Stall drops, PCNext=12, PCWrite pulse.
5. Halt=1 in DECODE at PCCur=7 -> PCNext=8, Halted=1; Start -> FETCH with IMemReq=1 and PCCur=8.
6. With PC_SEQ_CALL_STACK_EN defined:
   - Call at PC=3, Target=20 -> PC=20; Ret -> PC=4.
   - Ret on an empty stack -> PC+1 and StackErr=1.
   - 5 Calls with RS_DEPTH=4 -> StackErr=1.
